// File: rtl/sad_accumulate.sv
// sad_accumulate: accumulates five per-position row SADs over a block of ROWS words
// and reports the position with the smallest saturated total.
module sad_accumulate #(
    parameter int ROWS  = 8,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [59:0]        sad_in,
    input  logic               sad_valid,
    output logic               sad_ready,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2:0]         best_idx,
    output logic [ACC_W-1:0]   best_sad,
    output logic [5*ACC_W-1:0] sad_total,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;
    // Tie-break order after the initial full-pixel candidate: 1, 3, 0, 4
    localparam logic [11:0] ORDER = {3'd4, 3'd0, 3'd3, 3'd1};
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q [5];
    logic [ACC_W-1:0]   acc_d [5];
    logic [ACC_W:0]     sum [5];
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d, min_idx;
    logic [ACC_W-1:0]   best_q, best_d, min_val;
    logic [5*ACC_W-1:0] total_q, total_d;
    always_comb begin
        min_idx = 3'd2;
        min_val = acc_q[2];
        for (int i = 0; i < 4; i++) begin
            if (acc_q[ORDER[3*i +: 3]] < min_val) begin
                min_idx = ORDER[3*i +: 3];
                min_val = acc_q[ORDER[3*i +: 3]];
            end
        end
        for (int i = 0; i < 5; i++) sum[i] = {1'b0, acc_q[i]} + (ACC_W+1)'(sad_in[12*i +: 12]);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        best_d  = best_q;
        total_d = total_q;
        if ((state_q == IDLE || state_q == ACCUM) && start) begin
            state_d = ACCUM;
            cnt_d   = '0;
            for (int i = 0; i < 5; i++) acc_d[i] = '0;
        end else if (state_q == ACCUM && sad_valid) begin
            cnt_d = cnt_q + 8'd1;
            for (int i = 0; i < 5; i++) acc_d[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
            if (cnt_q == 8'(ROWS - 1)) state_d = COMPARE;
        end else if (state_q == COMPARE) begin
            state_d = DONE;
            idx_d   = min_idx;
            best_d  = min_val;
            for (int i = 0; i < 5; i++) total_d[ACC_W*i +: ACC_W] = acc_q[i];
        end else if (state_q == DONE && result_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '{default: '0};
            idx_q   <= '0;
            best_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            best_q  <= best_d;
            total_q <= total_d;
        end
    end
    assign sad_ready    = state_q == ACCUM;
    assign result_valid = state_q == DONE;
    assign busy         = state_q != IDLE;
    assign best_idx     = idx_q;
    assign best_sad     = best_q;
    assign sad_total    = total_q;
endmodule

// File: doc/sad_accumulate.md
SAD_ACCUMULATE -- requirements
Module: sad_accumulate

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning the number of row SAD words accumulated per block (legal range 1..256).
REQ-002 SHALL have parameter ACC_W, default 16, meaning the width of each per-position accumulator.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin a new block: clear accumulators and row count.
REQ-006 SHALL have port sad_in, input, 60, five packed 12-bit unsigned row SADs: [11:0] pos0 right quarter, [23:12] pos1 right half, [35:24] pos2 full pixel, [47:36] pos3 left half, [59:48] pos4 left quarter.
REQ-007 SHALL have port sad_valid, input, 1, sad_in holds a valid row word.
REQ-008 SHALL have port sad_ready, output, 1, the block accepts a row word this cycle.
REQ-009 SHALL have port result_valid, output, 1, best_idx, best_sad and sad_total are valid.
REQ-010 SHALL have port result_ready, input, 1, the consumer takes the result.
REQ-011 SHALL have port best_idx, output, 3, winning position index 0..4.
REQ-012 SHALL have port best_sad, output, ACC_W, accumulated SAD of the winner.
REQ-013 SHALL have port sad_total, output, 5*ACC_W, all five accumulators packed pos0 in the LSBs.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ACCUM, COMPARE and DONE.
REQ-016 In IDLE, start=1 SHALL move to ACCUM and clear the five accumulators and the row counter to 0.
REQ-017 sad_ready SHALL be 1 only in ACCUM; it SHALL be a registered function of state, with no combinational path from sad_valid.
REQ-018 A row word SHALL be accepted on an edge with sad_valid=1 and sad_ready=1.
REQ-019 On each accepted word, each field SHALL be zero-extended and added to its accumulator; the row counter SHALL increment.
REQ-020 Each accumulator SHALL saturate at 2^ACC_W-1 and never wrap.
REQ-021 Acceptance of row ROWS-1 (counter == ROWS-1) SHALL move the state to COMPARE on the same edge.
REQ-022 COMPARE SHALL last exactly one cycle; on its closing edge best_idx, best_sad and sad_total SHALL be registered and the state SHALL move to DONE.
REQ-023 Minimum selection SHALL use strict less-than in priority order 2, 1, 3, 0, 4, so ties prefer full pixel, then half, then quarter, and within each the right side.
REQ-024 result_valid SHALL be 1 exactly in DONE; outputs SHALL remain stable while result_valid=1 and result_ready=0.
REQ-025 In DONE, result_ready=1 SHALL move to IDLE on that edge; result_valid SHALL be 0 the next cycle.
REQ-026 Latency SHALL be: last row accepted at edge k, result_valid high from edge k+1.
REQ-027 start=1 in ACCUM SHALL restart: accumulators and counter cleared, any word offered that cycle discarded, state stays ACCUM.
REQ-028 start SHALL be ignored in COMPARE and DONE.
REQ-029 With ROWS=1, the first accepted word SHALL move directly to COMPARE.
REQ-030 best_idx, best_sad and sad_total SHALL hold their last values in IDLE and ACCUM until the next COMPARE.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, sad_ready=0, result_valid=0, busy=0, best_idx=0, best_sad=0, sad_total=0, accumulators and row counter 0.
REQ-032 Reset asserted mid-block SHALL discard all partial accumulation; after release the block SHALL wait in IDLE for start.

Verification
REQ-033 ROWS=8, start, 8 words each {pos4..pos0}={50,40,10,30,60} -> result_valid one cycle after the 8th accept, best_idx=2, best_sad=80, sad_total={400,320,80,240,480}.
REQ-034 All fields equal to 100 for 8 rows -> best_idx=2, best_sad=800; repeat with pos2=101 and the other fields 100 -> best_idx=1.
REQ-035 ACC_W=12, ROWS=8, all fields 4095 -> every accumulator = 4095 (saturated), best_idx=2.
REQ-036 sad_valid toggled randomly for 8 words, result_ready held 0 for 5 cycles in DONE -> sums exact, outputs stable and result_valid=1 throughout, busy=0 the cycle after result_ready=1.
REQ-037 start reasserted after 3 accepted words, then 8 words of pos0=1 and other fields 9 -> best_idx=0, best_sad=8.
REQ-038 rst pulsed between clock edges after 4 words -> outputs zero immediately, sad_ready=0; a new start and 8 words -> correct sums, with no residue from the aborted block.
